mem_port_arbiter: RTL and testbench

Arbitrates a single shared, single-ported memory between the pipeline's instruction-fetch port (read-only) and its data port (read/write). Each access is sequenced through a small FSM. Address, write data and write enable are latched at grant, and read data is returned with a one-cycle acknowledge pulse. Per-port stall outputs are provided so the pipeline can freeze PC/IFID, or the whole pipe, while its port waits. The block sits between the IF/MEM stages and the unified memory model.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and memory-side signals of mem_port_arbiter.
// slave = arbiter view, master = the pipeline/memory environment driving it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic              i_ack_o;
    logic [DATA_W-1:0] i_rdata_o;
    logic              i_stall_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic              d_ack_o;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_stall_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  i_req_i, i_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_ack_i, mem_rdata_i,
        output i_ack_o, i_rdata_o, i_stall_o,
        output d_ack_o, d_rdata_o, d_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output i_req_i, i_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_ack_i, mem_rdata_i,
        input  i_ack_o, i_rdata_o, i_stall_o,
        input  d_ack_o, d_rdata_o, d_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port.
// 3 cycles per access minimum (grant, memory, ack); a waiting port sees its stall held high.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    mem_port_arbiter_if.slave     bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int              SW         = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);
    localparam bit              GUARD_ON   = (MAX_D_STREAK != 0);

    logic [1:0]        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ack_q,     i_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic [SW-1:0]     d_streak_q,  d_streak_d;

    logic guard_hit;
    logic grant_d;
    logic grant_i;

    // The fetch port wins a contested cycle only once data has had its full streak.
    assign guard_hit = GUARD_ON && (d_streak_q == STREAK_MAX);
    assign grant_d   = bus.d_req_i && !(guard_hit && bus.i_req_i);
    assign grant_i   = bus.i_req_i && !grant_d;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        d_streak_d  = d_streak_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we_i;
                    mem_addr_d  = bus.d_addr_i;
                    mem_wdata_d = bus.d_wdata_i;
                    if (!bus.i_req_i) begin
                        d_streak_d = '0;
                    end else if (d_streak_q != STREAK_MAX) begin
                        d_streak_d = d_streak_q + SW'(1);
                    end
                end else if (grant_i) begin
                    state_d     = BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_addr_i;
                    mem_wdata_d = '0;
                    d_streak_d  = '0;
                end
            end
            BUSY_I: begin
                if (bus.mem_ack_i) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    i_rdata_d = bus.mem_rdata_i;
                    i_ack_d   = 1'b1;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack_i) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    d_ack_d   = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata_i;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            d_streak_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            d_streak_q  <= d_streak_d;
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.i_ack_o     = i_ack_q;
    assign bus.d_ack_o     = d_ack_q;
    assign bus.i_rdata_o   = i_rdata_q;
    assign bus.d_rdata_o   = d_rdata_q;

    // Stalls are combinational so the pipe can freeze in the same cycle the request appears.
    assign bus.i_stall_o = bus.i_req_i & ~i_ack_q;
    assign bus.d_stall_o = bus.d_req_i & ~d_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with the streak guard at 4, one with it disabled.
module tb_mem_port_arbiter;
    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b4 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) u_dut4 (
        .clk_i (clk_i), .rst_i (rst_i), .bus (b4));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(0)) u_dut0 (
        .clk_i (clk_i), .rst_i (rst_i), .bus (b0));

    int n_cmp  = 0;
    int n_fail = 0;

    int mem_wait  = 0;
    bit force_ack = 1'b0;
    int wr_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    int rsp_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEADBEEF : (a ^ 32'hC0DE0000);
    endfunction

    // Memory model for the guarded instance: acks after mem_wait extra cycles.
    always @(posedge clk_i) begin
        #2;
        if (!rst_i || !b4.mem_req_o) begin
            b4.mem_ack_i = 1'b0;
            rsp_cnt = 0;
        end else if (rsp_cnt == mem_wait) begin
            b4.mem_ack_i   = 1'b1;
            b4.mem_rdata_i = mem_word(b4.mem_addr_o);
            if (b4.mem_we_o) begin
                wr_cnt++;
                last_wr_addr = b4.mem_addr_o;
                last_wr_data = b4.mem_wdata_o;
            end
            rsp_cnt = 0;
        end else begin
            b4.mem_ack_i = 1'b0;
            rsp_cnt++;
        end
        if (force_ack) b4.mem_ack_i = 1'b1;
    end

    always @(posedge clk_i) begin
        #2;
        b0.mem_ack_i   = b0.mem_req_o && rst_i;
        b0.mem_rdata_i = mem_word(b0.mem_addr_o);
    end

    logic [7:0]  gq4[$];
    logic [7:0]  gq0[$];
    int          viol = 0;
    int          d_ack_cnt4 = 0;
    logic        prev_req4 = 1'b0, prev_req0 = 1'b0, prev_we4 = 1'b0;
    logic [31:0] prev_addr4 = '0, prev_wdata4 = '0;

    // Records grant order (fetch addresses sit below 0x80) and protocol violations.
    always @(posedge clk_i) begin
        #3;
        if (b4.mem_req_o && prev_req4 && (b4.mem_addr_o !== prev_addr4 ||
            b4.mem_we_o !== prev_we4 || b4.mem_wdata_o !== prev_wdata4)) viol++;
        if (b4.i_ack_o && b4.d_ack_o) viol++;
        if (b0.i_ack_o && b0.d_ack_o) viol++;
        if (b4.mem_req_o && !prev_req4) gq4.push_back((b4.mem_addr_o < 32'h80) ? 8'h49 : 8'h44);
        if (b0.mem_req_o && !prev_req0) gq0.push_back((b0.mem_addr_o < 32'h80) ? 8'h49 : 8'h44);
        if (b4.d_ack_o) d_ack_cnt4++;
        prev_req4   = b4.mem_req_o;
        prev_req0   = b0.mem_req_o;
        prev_we4    = b4.mem_we_o;
        prev_addr4  = b4.mem_addr_o;
        prev_wdata4 = b4.mem_wdata_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        b4.i_req_i = 0; b4.i_addr_i = '0; b4.d_req_i = 0; b4.d_we_i = 0; b4.d_addr_i = '0; b4.d_wdata_i = '0;
        b0.i_req_i = 0; b0.i_addr_i = '0; b0.d_req_i = 0; b0.d_we_i = 0; b0.d_addr_i = '0; b0.d_wdata_i = '0;
        b4.mem_ack_i = 0; b4.mem_rdata_i = '0; b0.mem_ack_i = 0; b0.mem_rdata_i = '0;
        #1 rst_i = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({b4.mem_req_o, b4.mem_we_o, b4.i_ack_o, b4.d_ack_o} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctl: got %b want 0000", {b4.mem_req_o, b4.mem_we_o, b4.i_ack_o, b4.d_ack_o});
        end
        n_cmp++;
        if ({b4.mem_addr_o, b4.mem_wdata_o, b4.i_rdata_o, b4.d_rdata_o} !== 128'h0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {b4.mem_addr_o, b4.mem_wdata_o, b4.i_rdata_o, b4.d_rdata_o});
        end
        b4.i_req_i = 1'b1;
        #1;
        n_cmp++;
        if ({b4.i_stall_o, b4.d_stall_o} !== 2'b10) begin
            n_fail++; $display("FAIL reset_stall: got %b want 10", {b4.i_stall_o, b4.d_stall_o});
        end
        b4.i_req_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        mem_wait = 0;
        b4.i_req_i = 1'b1; b4.i_addr_i = 32'h40;
        #1;
        n_cmp++;
        if (b4.i_stall_o !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_t: got %b want 1", b4.i_stall_o); end
        tick();
        n_cmp++;
        if ({b4.mem_req_o, b4.mem_we_o, b4.mem_addr_o, b4.i_stall_o} !== {1'b1, 1'b0, 32'h40, 1'b1}) begin
            n_fail++; $display("FAIL fetch_t1: got req=%b we=%b addr=%h stall=%b want 1 0 00000040 1",
                b4.mem_req_o, b4.mem_we_o, b4.mem_addr_o, b4.i_stall_o);
        end
        tick();
        n_cmp++;
        if ({b4.i_ack_o, b4.i_rdata_o, b4.i_stall_o, b4.mem_req_o} !== {1'b1, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL fetch_t2: got ack=%b rdata=%h stall=%b req=%b want 1 deadbeef 0 0",
                b4.i_ack_o, b4.i_rdata_o, b4.i_stall_o, b4.mem_req_o);
        end
        b4.i_req_i = 1'b0;
        tick();
        n_cmp++;
        if ({b4.i_ack_o, b4.mem_req_o} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_t3: got ack/req %b want 00", {b4.i_ack_o, b4.mem_req_o});
        end
    endtask

    task automatic test_write_wait();
        int acks0 = d_ack_cnt4;
        int wr0   = wr_cnt;
        mem_wait = 2;
        b4.d_req_i = 1'b1; b4.d_we_i = 1'b1; b4.d_addr_i = 32'h80; b4.d_wdata_i = 32'h1234;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({b4.mem_req_o, b4.mem_we_o, b4.mem_addr_o, b4.mem_wdata_o, b4.d_ack_o, b4.d_stall_o} !==
                {1'b1, 1'b1, 32'h80, 32'h1234, 1'b0, 1'b1}) begin
                n_fail++; $display("FAIL write_hold_c%0d: got req=%b we=%b addr=%h wdata=%h ack=%b stall=%b want 1 1 00000080 00001234 0 1",
                    c, b4.mem_req_o, b4.mem_we_o, b4.mem_addr_o, b4.mem_wdata_o, b4.d_ack_o, b4.d_stall_o);
            end
        end
        tick();
        n_cmp++;
        if ({b4.d_ack_o, b4.d_rdata_o, b4.d_stall_o} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL write_ack: got ack=%b rdata=%h stall=%b want 1 00000000 0",
                b4.d_ack_o, b4.d_rdata_o, b4.d_stall_o);
        end
        b4.d_req_i = 1'b0; b4.d_we_i = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (d_ack_cnt4 - acks0 !== 1) begin n_fail++; $display("FAIL write_pulses: got %0d want 1", d_ack_cnt4 - acks0); end
        n_cmp++;
        if ({wr_cnt - wr0, last_wr_addr, last_wr_data} !== {32'd1, 32'h80, 32'h1234}) begin
            n_fail++; $display("FAIL write_mem: got n=%0d addr=%h data=%h want 1 00000080 00001234",
                wr_cnt - wr0, last_wr_addr, last_wr_data);
        end
        mem_wait = 0;
    endtask

    task automatic test_simultaneous();
        int n = 0;
        int start = gq4.size();
        b4.i_req_i = 1'b1; b4.i_addr_i = 32'h48;
        b4.d_req_i = 1'b1; b4.d_we_i = 1'b0; b4.d_addr_i = 32'h300;
        do begin tick(); n++; end while (!b4.d_ack_o && n < 20);
        n_cmp++;
        if ({b4.d_ack_o, b4.d_rdata_o, b4.i_ack_o} !== {1'b1, 32'hC0DE0300, 1'b0} || n != 2) begin
            n_fail++; $display("FAIL simul_d: got ack=%b rdata=%h iack=%b after %0d want 1 c0de0300 0 after 2",
                b4.d_ack_o, b4.d_rdata_o, b4.i_ack_o, n);
        end
        b4.d_req_i = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!b4.i_ack_o && n < 20);
        n_cmp++;
        if ({b4.i_ack_o, b4.i_rdata_o} !== {1'b1, 32'hC0DE0048} || n != 3) begin
            n_fail++; $display("FAIL simul_i: got ack=%b rdata=%h after %0d want 1 c0de0048 after 3",
                b4.i_ack_o, b4.i_rdata_o, n);
        end
        b4.i_req_i = 1'b0;
        tick(); tick();
        n_cmp++;
        if (gq4.size() != start + 2 || gq4[start] !== 8'h44 || gq4[start+1] !== 8'h49) begin
            n_fail++; $display("FAIL simul_order: got %0d grants want D then I", gq4.size() - start);
        end
    endtask

    task automatic test_starvation_guard();
        string exp_s = "DDDDIDD";
        int start = gq4.size();
        bit to_i = 1'b0, to_d = 1'b0;
        b4.i_req_i = 1'b1; b4.i_addr_i = 32'h44;
        b4.d_req_i = 1'b1; b4.d_we_i = 1'b0; b4.d_addr_i = 32'h200;
        fork
            begin
                int n = 0;
                do begin tick(); n++; end while (!b4.i_ack_o && n < 100);
                if (!b4.i_ack_o) to_i = 1'b1;
                b4.i_req_i = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    int n = 0;
                    b4.d_addr_i = 32'h200 + 32'(4 * k);
                    do begin tick(); n++; end while (!b4.d_ack_o && n < 100);
                    if (!b4.d_ack_o) to_d = 1'b1;
                end
                b4.d_req_i = 1'b0;
            end
        join
        tick(); tick();
        n_cmp++;
        if (to_i || to_d) begin n_fail++; $display("FAIL guard_timeout: got i=%b d=%b want 0 0", to_i, to_d); end
        n_cmp++;
        if (gq4.size() - start != 7) begin
            n_fail++; $display("FAIL guard_count: got %0d grants want 7", gq4.size() - start);
        end else begin
            for (int j = 0; j < 7; j++) begin
                n_cmp++;
                if (gq4[start+j] !== exp_s[j]) begin
                    n_fail++; $display("FAIL guard_order_%0d: got %s want %s", j, string'(gq4[start+j]), string'(exp_s[j]));
                end
            end
        end
    endtask

    task automatic test_strict_priority();
        string exp_s = "DDDDDDI";
        int start = gq0.size();
        bit to_i = 1'b0, to_d = 1'b0;
        b0.i_req_i = 1'b1; b0.i_addr_i = 32'h44;
        b0.d_req_i = 1'b1; b0.d_we_i = 1'b0; b0.d_addr_i = 32'h200;
        fork
            begin
                int n = 0;
                do begin tick(); n++; end while (!b0.i_ack_o && n < 100);
                if (!b0.i_ack_o) to_i = 1'b1;
                b0.i_req_i = 1'b0;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    int n = 0;
                    b0.d_addr_i = 32'h200 + 32'(4 * k);
                    do begin tick(); n++; end while (!b0.d_ack_o && n < 100);
                    if (!b0.d_ack_o) to_d = 1'b1;
                end
                b0.d_req_i = 1'b0;
            end
        join
        tick(); tick();
        n_cmp++;
        if (to_i || to_d) begin n_fail++; $display("FAIL strict_timeout: got i=%b d=%b want 0 0", to_i, to_d); end
        n_cmp++;
        if (gq0.size() - start != 7) begin
            n_fail++; $display("FAIL strict_count: got %0d grants want 7", gq0.size() - start);
        end else begin
            for (int j = 0; j < 7; j++) begin
                n_cmp++;
                if (gq0[start+j] !== exp_s[j]) begin
                    n_fail++; $display("FAIL strict_order_%0d: got %s want %s", j, string'(gq0[start+j]), string'(exp_s[j]));
                end
            end
        end
        n_cmp++;
        if (b0.i_rdata_o !== 32'hC0DE0044) begin
            n_fail++; $display("FAIL strict_irdata: got %h want c0de0044", b0.i_rdata_o);
        end
    endtask

    task automatic test_reset_mid_access();
        int acks0;
        int n = 0;
        mem_wait = 10;
        b4.d_req_i = 1'b1; b4.d_we_i = 1'b0; b4.d_addr_i = 32'h300;
        tick();
        n_cmp++;
        if (b4.mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got req=%b want 1", b4.mem_req_o); end
        acks0 = d_ack_cnt4;
        #2 rst_i = 1'b0;
        #1;
        n_cmp++;
        if (b4.mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_drop: got req=%b want 0", b4.mem_req_o); end
        force_ack = 1'b1;
        b4.d_req_i = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({b4.d_ack_o, b4.mem_req_o, b4.d_rdata_o} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL rst_hold: got ack=%b req=%b rdata=%h want 0 0 00000000",
                b4.d_ack_o, b4.mem_req_o, b4.d_rdata_o);
        end
        rst_i = 1'b1;
        force_ack = 1'b0;
        mem_wait = 0;
        tick();
        b4.i_req_i = 1'b1; b4.i_addr_i = 32'h40;
        do begin tick(); n++; end while (!b4.i_ack_o && n < 20);
        n_cmp++;
        if ({b4.i_ack_o, b4.i_rdata_o} !== {1'b1, 32'hDEADBEEF} || n != 2) begin
            n_fail++; $display("FAIL rst_refetch: got ack=%b rdata=%h after %0d want 1 deadbeef after 2",
                b4.i_ack_o, b4.i_rdata_o, n);
        end
        b4.i_req_i = 1'b0;
        tick(); tick();
        n_cmp++;
        if (d_ack_cnt4 != acks0) begin
            n_fail++; $display("FAIL rst_no_dack: got %0d acks want 0", d_ack_cnt4 - acks0);
        end
    endtask

    task automatic test_invariants();
        n_cmp++;
        if (viol != 0) begin n_fail++; $display("FAIL invariants: got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_write_wait();
        test_simultaneous();
        test_starvation_guard();
        test_strict_priority();
        test_reset_mid_access();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
